// File: rtl/instr_fetch_issue.sv
// Fetch/issue sequencer: fetches 16-bit instructions, issues each to the control unit once,
// and handles branch, self-injection and end-of-program. Optional issue counter: FETCH_ISSUE_CNT_EN.
module instr_fetch_issue #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned SELF_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  input  logic        stall_i,
  output logic [15:0] instr_o,
  output logic        cu_input_en_o,
  output logic [15:0] pc_o,
  input  logic        branch_i,
  input  logic [15:0] branch_target_i,
  input  logic [15:0] self_instruct_i,
  input  logic        self_instruct_en_i,
  input  logic        end_program_i,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] issue_cnt_o
);
  localparam int SCW = $clog2(SELF_MAX + 2);

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALT} state_t;

  state_t         state_q;
  logic [15:0]    pc_q, pc_d;
  logic [15:0]    instr_q;
  logic [SCW-1:0] self_cnt_q;
  logic           fault_q;
  logic           cu_en;

  assign cu_en = (state_q == S_ISSUE) && !stall_i;

  // Branch targets are forced halfword aligned; sequential flow wraps naturally at 16 bits.
  always_comb begin
    pc_d = pc_q + 16'd2;
    if (branch_i) pc_d = branch_target_i & 16'hFFFE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      self_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: if (imem_ack_i) begin
          instr_q <= imem_data_i;
          state_q <= S_ISSUE;
        end
        S_ISSUE: if (!stall_i) begin
          if (end_program_i) begin
            state_q <= S_HALT;
          end else if (self_instruct_en_i) begin
            if (self_cnt_q == SCW'(SELF_MAX)) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              instr_q    <= self_instruct_i;
              self_cnt_q <= self_cnt_q + SCW'(1);
            end
          end else begin
            pc_q       <= pc_d;
            self_cnt_q <= '0;
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Request is masked by reset so it drops the moment reset asserts.
  assign imem_req_o    = (state_q == S_FETCH) && !rst_i;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign cu_input_en_o = cu_en;
  assign halted_o      = (state_q == S_HALT);
  assign fault_o       = fault_q;

`ifdef FETCH_ISSUE_CNT_EN
  logic [31:0] issue_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      issue_cnt_q <= '0;
    else if (cu_en) issue_cnt_q <= issue_cnt_q + 32'd1;
  end
  assign issue_cnt_o = issue_cnt_q;
`else
  assign issue_cnt_o = '0;
`endif
endmodule

// File: doc/instr_fetch_issue.md
# instr_fetch_issue

Instruction fetch and issue sequencer feeding the Thumb-subset control unit. Fetches 16-bit instructions from instruction memory over a req/ack handshake, presents each one to the control unit for exactly one enabled cycle, and reacts to the control unit's same-cycle responses: branch, self-instruction injection (push/pop expansion) and end-of-program. Sits between instruction memory and the control unit and owns the program counter.

## Interface
- `RESET_PC`, 16'h0000: PC loaded on reset; must be halfword aligned.
- `SELF_MAX`, 4: maximum consecutive self-injected instructions before fault.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 16: fetch byte address, equals PC.
- `imem_ack_i` in 1: fetch data valid this cycle.
- `imem_data_i` in 16: fetched instruction.
- `stall_i` in 1: back end busy; holds issue.
- `instr_o` out 16: instruction to control unit `in`.
- `cu_input_en_o` out 1: to control unit `cu_input_en_i`.
- `pc_o` out 16: PC of the instruction on `instr_o`.
- `branch_i` in 1: branch taken (control unit `branch`).
- `branch_target_i` in 16: branch destination from datapath.
- `self_instruct_i` in 16, `self_instruct_en_i` in 1: injection request.
- `end_program_i` in 1: program end.
- `halted_o` out 1: sequencer halted.
- `fault_o` out 1: self-injection chain exceeded `SELF_MAX`.
- `issue_cnt_o` out 32: issued-instruction count (see Configuration).

## Operation
- States: FETCH, ISSUE, HALT. Reset state FETCH.
- FETCH: `imem_req_o`=1, `imem_addr_o`=PC held stable until `imem_ack_i` sampled 1; `imem_data_i` captured into `instr_o` on that edge; go ISSUE.
- ISSUE: `cu_input_en_o` = ~`stall_i`. While `stall_i`=1 stay, `instr_o`/`pc_o` held. When enable is 1 the control unit responds combinationally; responses sampled at the end of that cycle, priority:
  1. `end_program_i` -> HALT.
  2. `self_instruct_en_i` -> `instr_o` <= `self_instruct_i`, PC unchanged, self counter +1, stay ISSUE. If counter would exceed `SELF_MAX` -> `fault_o`=1, HALT.
  3. `branch_i` -> PC <= {`branch_target_i`[15:1],1'b0}, self counter cleared, FETCH.
  4. else PC <= PC+2 (16-bit wrap, 16'hFFFE -> 16'h0000), self counter cleared, FETCH.
- Response inputs are ignored whenever `cu_input_en_o`=0.
- HALT: `halted_o`=1, `imem_req_o`=0, `cu_input_en_o`=0; left only by reset. `instr_o`, `pc_o` frozen.
- `pc_o` = PC of the originating fetched instruction, also during injected instructions.
- `imem_ack_i` outside FETCH is ignored.

## Timing
- Reset values: PC=`RESET_PC`, `instr_o`=0, `cu_input_en_o`=0, `imem_req_o`=0 while `rst_i` high, `halted_o`=0, `fault_o`=0, `issue_cnt_o`=0, self counter 0.
- First cycle after reset release: `imem_req_o`=1 (combinational from state).
- Ack at edge N -> `cu_input_en_o`=1 in cycle N+1 (no stall). Fetch-to-fetch minimum 2 cycles with zero-wait memory.
- Self injection: request in issue cycle N -> injected instruction enabled in cycle N+1, no memory access.
- Branch/sequential: next `imem_req_o` in cycle N+1 with new address.
- Reset mid-FETCH: request drops asynchronously; a late ack after release is ignored unless in FETCH.
- All outputs registered or decoded from state only; no combinational path from response inputs to outputs.

## Configuration
- `FETCH_ISSUE_CNT_EN` defined: `issue_cnt_o` increments (32-bit wrap) on every cycle with `cu_input_en_o`=1, including injected instructions.
- Not defined: counter not built, `issue_cnt_o` tied to 0.

## Test plan
- Reset, memory returns 16'h2005 (MOV r0,#5) with 1-cycle ack, no responses -> `imem_addr_o` 0x0000 then 0x0002, one enable pulse with `instr_o`=16'h2005, `pc_o`=0.
- Stall: `stall_i`=1 for 3 cycles in ISSUE -> `cu_input_en_o` low 3 cycles, then exactly one pulse; `instr_o` stable throughout.
- PUSH 16'hB500 issued, `self_instruct_en_i`=1 with 16'h9701 -> next cycle `instr_o`=16'h9701 enabled, `pc_o` unchanged, then fetch at PC+2.
- `branch_i`=1, `branch_target_i`=16'h0041 -> next `imem_addr_o`=16'h0040; simultaneous `self_instruct_en_i` wins, branch ignored.
- `end_program_i`=1 on instruction 16'h0000 -> `halted_o`=1 next cycle, no further `imem_req_o`; `self_instruct_en_i` held 1 for 5 issues with `SELF_MAX`=4 -> `fault_o`=1, halted.
- PC at 16'hFFFE sequential -> next fetch 16'h0000; with `FETCH_ISSUE_CNT_EN`, `issue_cnt_o` equals enable pulses counted, else 0.
